// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared issue-queue payload types and widths for the MIPS core
package mips_core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_PASS
  } AluCtl;

  typedef enum logic [1:0] {
    MEM_NONE, MEM_LOAD, MEM_STORE
  } MemAccessType;

  localparam int PHYS_TAG_W = 6;

  typedef struct packed {
    AluCtl                 alu_ctl;
    logic                  is_branch_jump;
    logic                  is_jump;
    logic                  is_jump_reg;
    logic [31:0]           branch_target;
    logic                  is_mem_access;
    MemAccessType          mem_action;
    logic                  uses_rs;
    logic [PHYS_TAG_W-1:0] rs_tag;
    logic                  uses_rt;
    logic [PHYS_TAG_W-1:0] rt_tag;
    logic                  uses_immediate;
    logic [31:0]           immediate;
    logic                  uses_rw;
    logic [PHYS_TAG_W-1:0] rw_tag;
    logic                  is_ll;
    logic                  is_sc;
    logic                  is_sw;
  } iq_payload_t;

  localparam int IQ_PAYLOAD_W = $bits(iq_payload_t);

endpackage

// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - finds the lowest or highest index whose bit equals SIGNAL
module priority_encoder #(
  parameter int NUM_OF_INPUTS = 32,
  parameter bit HIGH_PRIORITY = 1'b0,
  parameter bit SIGNAL        = 1'b1,
  localparam int IDX_W        = (NUM_OF_INPUTS > 1) ? $clog2(NUM_OF_INPUTS) : 1
) (
  input  logic [NUM_OF_INPUTS-1:0] req,
  output logic                     found,
  output logic [IDX_W-1:0]         idx
);

  // Ascending scan: first match wins for low priority, last match wins for high priority
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_OF_INPUTS; i++) begin
      if ((req[i] == SIGNAL) && (HIGH_PRIORITY || !found)) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/instruction_queue_ifc.sv
// rtl/instruction_queue_ifc.sv - out-of-order issue queue; IQ_OCCUPANCY_EN adds registered count output
module instruction_queue_ifc
  import mips_core_pkg::*;
#(
  parameter int IQ_DEPTH = 32,
  parameter int PRF_SIZE = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [IQ_PAYLOAD_W-1:0] in_payload,
  output logic                    in_ready,
  input  logic [PRF_SIZE-1:0]     prf_ready,
  input  logic                    flush,
  input  logic [31:0]             flush_id,
  input  logic                    flush_done,
  output logic                    out_valid,
  output logic [IQ_PAYLOAD_W-1:0] out_payload,
  output logic [31:0]             out_id
`ifdef IQ_OCCUPANCY_EN
  ,
  output logic [5:0]              count
`endif
);

  localparam int IDX_W = $clog2(IQ_DEPTH);

  logic [IQ_DEPTH-1:0] valid_entry;
  logic [IQ_DEPTH-1:0] valid_next;
  logic [IQ_DEPTH-1:0] entry_ready;
  logic [IQ_DEPTH-1:0] squash;
  logic [IQ_DEPTH-1:0] issue_req;
  iq_payload_t         payload_mem [IQ_DEPTH];
  logic [31:0]         id_mem      [IQ_DEPTH];
  logic                blocked;
  logic [31:0]         next_id;
  logic                free_found;
  logic                issue_found;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    issue_idx;
  logic                full;
  logic                enq;

  // Operand readiness from stored tags, and wrap-safe "younger than flush_id" squash mask
  always_comb begin
    entry_ready = '0;
    squash      = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      entry_ready[i] = (!payload_mem[i].uses_rs || prf_ready[payload_mem[i].rs_tag]) &&
                       (!payload_mem[i].uses_rt || prf_ready[payload_mem[i].rt_tag]);
      squash[i]      = flush && valid_entry[i] && ($signed(id_mem[i] - flush_id) > 0);
    end
  end

  assign issue_req = valid_entry & entry_ready & ~squash;
  assign full      = &valid_entry;
  assign in_ready  = !full && !blocked && !flush;
  assign enq       = in_valid && in_ready && free_found;

  priority_encoder #(
    .NUM_OF_INPUTS(IQ_DEPTH),
    .HIGH_PRIORITY(1'b0),
    .SIGNAL       (1'b0)
  ) u_free_slot (
    .req  (valid_entry),
    .found(free_found),
    .idx  (free_idx)
  );

  priority_encoder #(
    .NUM_OF_INPUTS(IQ_DEPTH),
    .HIGH_PRIORITY(1'b1),
    .SIGNAL       (1'b1)
  ) u_issue_sel (
    .req  (issue_req),
    .found(issue_found),
    .idx  (issue_idx)
  );

  // Next occupancy: drop squashed and issued entries, then add the newly allocated one
  always_comb begin
    valid_next = valid_entry & ~squash;
    if (issue_found) valid_next[issue_idx] = 1'b0;
    if (enq)         valid_next[free_idx]  = 1'b1;
  end

  // Control state and registered issue outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_entry <= '0;
      blocked     <= 1'b0;
      next_id     <= '0;
      out_valid   <= 1'b0;
      out_id      <= '0;
      out_payload <= '0;
    end else begin
      valid_entry <= valid_next;
      out_valid   <= issue_found;
      if (issue_found) begin
        out_payload <= payload_mem[issue_idx];
        out_id      <= id_mem[issue_idx];
      end
      if (flush) begin
        blocked <= 1'b1;
        next_id <= flush_id + 32'd1;
      end else begin
        if (flush_done) blocked <= 1'b0;
        if (enq)        next_id <= next_id + 32'd1;
      end
    end
  end

  // Entry storage is qualified by valid_entry, so it needs no reset
  always_ff @(posedge clk) begin
    if (enq) begin
      payload_mem[free_idx] <= iq_payload_t'(in_payload);
      id_mem[free_idx]      <= next_id;
    end
  end

`ifdef IQ_OCCUPANCY_EN
  logic [5:0] count_next;

  // Population count of the next-cycle valid mask
  always_comb begin
    count_next = '0;
    for (int i = 0; i < IQ_DEPTH; i++) count_next = count_next + 6'(valid_next[i]);
  end

  // Registered occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_next;
  end
`endif

endmodule

// File: tb/tb_instruction_queue_ifc.sv
// tb/tb_instruction_queue_ifc.sv - randomized self-checking bench with behavioural issue-queue model
module tb_instruction_queue_ifc;
  import mips_core_pkg::*;

  localparam int DEPTH = 32;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic [IQ_PAYLOAD_W-1:0] in_payload = '0;
  logic                    in_ready;
  logic [63:0]             prf_ready = '1;
  logic                    flush = 1'b0;
  logic [31:0]             flush_id = '0;
  logic                    flush_done = 1'b0;
  logic                    out_valid;
  logic [IQ_PAYLOAD_W-1:0] out_payload;
  logic [31:0]             out_id;
`ifdef IQ_OCCUPANCY_EN
  logic [5:0]              count;
`endif

  instruction_queue_ifc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_payload (in_payload),
    .in_ready   (in_ready),
    .prf_ready  (prf_ready),
    .flush      (flush),
    .flush_id   (flush_id),
    .flush_done (flush_done),
    .out_valid  (out_valid),
    .out_payload(out_payload),
    .out_id     (out_id)
`ifdef IQ_OCCUPANCY_EN
    ,
    .count      (count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  bit          m_valid [DEPTH];
  iq_payload_t m_pl    [DEPTH];
  logic [31:0] m_id    [DEPTH];
  bit          m_blocked;
  logic [31:0] m_next_id;
  bit          m_out_valid;
  logic [31:0] m_out_id;
  iq_payload_t m_out_pl;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int occupancy();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic bit exp_in_ready();
    return (occupancy() < DEPTH) && !m_blocked && !flush;
  endfunction

  function automatic bit pl_ready(input iq_payload_t p, input logic [63:0] prf);
    return (!p.uses_rs || prf[p.rs_tag]) && (!p.uses_rt || prf[p.rt_tag]);
  endfunction

  function automatic iq_payload_t rand_pl();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return iq_payload_t'(r[IQ_PAYLOAD_W-1:0]);
  endfunction

  function automatic iq_payload_t mk_pl(input bit urs, input int rs, input bit urt, input int rt);
    iq_payload_t p;
    p = rand_pl();
    p.uses_rs = urs;
    p.rs_tag  = 6'(rs);
    p.uses_rt = urt;
    p.rt_tag  = 6'(rt);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_blocked   = 1'b0;
    m_next_id   = '0;
    m_out_valid = 1'b0;
    m_out_id    = '0;
    m_out_pl    = '0;
  endtask

  // One clock edge of the queue's rules, using the inputs sampled at that edge
  task automatic model_step();
    bit sq [DEPTH];
    int ii;
    int fi;
    bit enq;
    if (!rst_n) begin
      model_reset();
      return;
    end
    enq = in_valid && exp_in_ready();
    ii = -1;
    fi = -1;
    for (int i = 0; i < DEPTH; i++)
      sq[i] = flush && m_valid[i] && (int'(m_id[i] - flush_id) > 0);
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && !sq[i] && pl_ready(m_pl[i], prf_ready)) ii = i;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!m_valid[i]) fi = i;
    m_out_valid = (ii >= 0);
    if (ii >= 0) begin
      m_out_id    = m_id[ii];
      m_out_pl    = m_pl[ii];
      m_valid[ii] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) if (sq[i]) m_valid[i] = 1'b0;
    if (enq) begin
      m_valid[fi] = 1'b1;
      m_pl[fi]    = iq_payload_t'(in_payload);
      m_id[fi]    = m_next_id;
      m_next_id   = m_next_id + 32'd1;
    end
    if (flush) begin
      m_blocked = 1'b1;
      m_next_id = flush_id + 32'd1;
    end else if (flush_done) begin
      m_blocked = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 128'(out_valid), 128'(m_out_valid));
      check("out_id", 128'(out_id), 128'(m_out_id));
      check("out_payload", 128'(out_payload), 128'(m_out_pl));
      check("in_ready", 128'(in_ready), 128'(exp_in_ready()));
`ifdef IQ_OCCUPANCY_EN
      check("count", 128'(count), 128'(occupancy()));
`endif
    end
  end

  task automatic do_reset();
    in_valid   = 1'b0;
    flush      = 1'b0;
    flush_done = 1'b0;
    prf_ready  = '1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_out_valid", 128'(out_valid), 128'(0));
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_out_id", 128'(out_id), 128'(0));
    check("rst_out_payload", 128'(out_payload), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
  endtask

  task automatic enq_one(input iq_payload_t p);
    in_valid   = 1'b1;
    in_payload = p;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    #1;
    check("init_out_valid", 128'(out_valid), 128'(0));
    check("init_in_ready", 128'(in_ready), 128'(1));

    // Single ready instruction issues on the next edge with ID 0
    enq_one(mk_pl(1'b1, 5, 1'b0, 0));
    tick();
    check("first_issue_valid", 128'(out_valid), 128'(1));
    check("first_issue_id", 128'(out_id), 128'(0));
    tick();
    check("first_issue_once", 128'(out_valid), 128'(0));

    // Waits on rs_tag 7, then issues the edge after it becomes ready
    prf_ready    = '1;
    prf_ready[7] = 1'b0;
    enq_one(mk_pl(1'b1, 7, 1'b0, 0));
    for (int c = 0; c < 5; c++) tick();
    check("wait_operand_no_issue", 128'(out_valid), 128'(0));
    prf_ready[7] = 1'b1;
    tick();
    check("operand_ready_issue", 128'(out_valid), 128'(1));
    check("operand_ready_id", 128'(out_id), 128'(1));

    // Fill all entries; the 33rd instruction is dropped
    do_reset();
    prf_ready = '0;
    in_valid  = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      in_payload = mk_pl(1'b1, $urandom_range(0, 63), $urandom_range(0, 1), $urandom_range(0, 63));
      tick();
    end
    check("full_in_ready", 128'(in_ready), 128'(0));
    tick();
    in_valid  = 1'b0;
    prf_ready = '1;
    tick();
    check("full_drain_first_id", 128'(out_id), 128'(31));
    for (int c = 0; c < DEPTH; c++) tick();
    enq_one(mk_pl(1'b0, 0, 1'b0, 0));
    tick();
    check("after_drop_next_id", 128'(out_id), 128'(32));

    // Flush squashes IDs 5..9 and blocks until flush_done
    do_reset();
    prf_ready = '0;
    for (int k = 0; k < 10; k++) enq_one(mk_pl(1'b1, 9, 1'b0, 0));
    flush      = 1'b1;
    flush_id   = 32'd4;
    in_valid   = 1'b1;
    in_payload = mk_pl(1'b0, 0, 1'b0, 0);
    #1;
    check("flush_cycle_in_ready", 128'(in_ready), 128'(0));
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("blocked_in_ready", 128'(in_ready), 128'(0));
    tick();
    flush_done = 1'b1;
    tick();
    flush_done = 1'b0;
    check("unblocked_in_ready", 128'(in_ready), 128'(1));
    enq_one(mk_pl(1'b0, 0, 1'b0, 0));
    tick();
    check("post_flush_id", 128'(out_id), 128'(5));
    prf_ready = '1;
    tick();
    check("flush_survivor_id", 128'(out_id), 128'(4));
    for (int c = 0; c < 8; c++) tick();

    // Highest ready index issues first
    do_reset();
    prf_ready = '0;
    enq_one(mk_pl(1'b1, 10, 1'b0, 0));
    enq_one(mk_pl(1'b1, 10, 1'b0, 0));
    enq_one(mk_pl(1'b1, 20, 1'b0, 0));
    enq_one(mk_pl(1'b1, 20, 1'b0, 0));
    prf_ready[20] = 1'b1;
    tick();
    check("prio_first_id", 128'(out_id), 128'(3));
    tick();
    check("prio_second_id", 128'(out_id), 128'(2));
    tick();
    check("prio_done", 128'(out_valid), 128'(0));

    // Asynchronous reset mid-stream with 10 entries
    do_reset();
    prf_ready = '0;
    for (int k = 0; k < 10; k++) enq_one(mk_pl(1'b1, 33, 1'b0, 0));
    prf_ready = '1;
    tick();
    check("pre_reset_issue", 128'(out_valid), 128'(1));
    do_reset();
    for (int c = 0; c < 5; c++) tick();
    check("post_reset_empty", 128'(out_valid), 128'(0));

    // Randomized traffic across several operand-readiness densities
    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 800; c++) begin
        logic [63:0] r1;
        logic [63:0] r2;
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        case (seg)
          0: prf_ready = r1 | r2;
          1: prf_ready = r1;
          2: prf_ready = r1 & r2;
          default: prf_ready = '1;
        endcase
        in_valid   = ($urandom_range(0, 99) < 65);
        in_payload = rand_pl();
        flush      = ($urandom_range(0, 99) < 4);
        flush_id   = m_next_id - 32'($urandom_range(0, 12)) + 32'($urandom_range(0, 2));
        flush_done = ($urandom_range(0, 99) < 20);
        tick();
      end
    end
    in_valid   = 1'b0;
    flush      = 1'b0;
    flush_done = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
